reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/regfile_pkg.sv | 7 +
 rtl/eq_nbits.sv | 12 +
 rtl/reg_scoreboard.sv | 98 +++++++++
 tb/tb_reg_scoreboard.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// regfile_pkg: shared register-file constants for the scoreboard slice.
package regfile_pkg;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int R0             = 0;
endpackage
`default_nettype wire

// File: rtl/eq_nbits.sv
`default_nettype none
// eq_nbits: W-bit equality comparator.
module eq_nbits #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);
  assign eq = (a == b);
endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// reg_scoreboard: circular FIFO of pending register writes with
// zero-latency source-operand hazard lookup.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int NUM_SRC = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic [ADDR_W-1:0]           issue_dest,
  output logic                        issue_ready,
  input  logic                        retire_valid,
  output logic [ADDR_W-1:0]           retire_dest,
  input  logic                        flush,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  output logic [NUM_SRC-1:0]          src_hazard,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        empty,
  output logic                        full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              do_issue;
  logic              do_retire;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign count       = count_q;
  assign issue_ready = !full;
  assign retire_dest = empty ? '0 : dest_q[rd_ptr];

  // Register 0 is hardwired, so writes to it never create a hazard.
  assign do_issue  = issue_valid && issue_ready && (issue_dest != ADDR_W'(R0));
  assign do_retire = retire_valid && !empty;

  // Issue and retire never touch the same slot: that needs wr==rd, i.e.
  // empty (retire blocked) or full (issue blocked).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (do_issue) begin
        dest_q[wr_ptr]  <= issue_dest;
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (do_retire) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
      if (do_issue && !do_retire) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!do_issue && do_retire) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [ADDR_W-1:0] src_k;
    logic [DEPTH-1:0]  hit;
    assign src_k = src_addr[k*ADDR_W +: ADDR_W];

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      logic match;
      eq_nbits #(.W(ADDR_W)) u_eq (
        .a  (dest_q[e]),
        .b  (src_k),
        .eq (match)
      );
      assign hit[e] = valid_q[e] & match;
    end

    assign src_hazard[k] = (src_k != ADDR_W'(R0)) && (|hit);
  end
endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// tb_reg_scoreboard: directed vector table plus reset/flush sequences.
module tb_reg_scoreboard;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_dest = '0;
  logic        issue_ready;
  logic        retire_valid = 1'b0;
  logic [4:0]  retire_dest;
  logic        flush = 1'b0;
  logic [9:0]  src_addr = '0;
  logic [1:0]  src_hazard;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int n_cmp = 0;
  int n_bad = 0;

  reg_scoreboard #(.ADDR_W(5), .DEPTH(4), .NUM_SRC(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest),
    .issue_ready  (issue_ready),
    .retire_valid (retire_valid),
    .retire_dest  (retire_dest),
    .flush        (flush),
    .src_addr     (src_addr),
    .src_hazard   (src_hazard),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  always #5 clock = ~clock;

  // Expected values describe the state before this vector's clock edge,
  // with this vector's inputs already applied.
  typedef struct {
    logic       iv;
    logic [4:0] idest;
    logic       rv;
    logic       fl;
    logic [4:0] s1;
    logic [4:0] s0;
    logic [1:0] hz;
    int         cnt;
    logic [4:0] rdest;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [4:0] idest, logic rv, logic fl,
                              logic [4:0] s1, logic [4:0] s0,
                              logic [1:0] hz, int cnt, logic [4:0] rdest);
    vec_t v;
    v.iv = iv; v.idest = idest; v.rv = rv; v.fl = fl;
    v.s1 = s1; v.s0 = s0; v.hz = hz; v.cnt = cnt; v.rdest = rdest;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [1:0] hz, int cnt, logic [4:0] rdest);
    chk({tag, " hazard"}, 32'(src_hazard), 32'(hz));
    chk({tag, " count"}, 32'(count), 32'(cnt));
    chk({tag, " empty"}, 32'(empty), 32'(cnt == 0));
    chk({tag, " full"}, 32'(full), 32'(cnt == 4));
    chk({tag, " issue_ready"}, 32'(issue_ready), 32'(cnt != 4));
    chk({tag, " retire_dest"}, 32'(retire_dest), 32'(rdest));
  endtask

  task automatic drive(logic iv, logic [4:0] idest, logic rv, logic fl,
                       logic [4:0] s1, logic [4:0] s0);
    issue_valid  = iv;
    issue_dest   = idest;
    retire_valid = rv;
    flush        = fl;
    src_addr     = {s1, s0};
  endtask

  initial begin
    //                iv dst rv fl  s1  s0  hz     cnt rdest
    vecs.push_back(mk(0, 0,  0, 0,  7,  3,  2'b00, 0,  0));
    vecs.push_back(mk(1, 3,  0, 0,  7,  3,  2'b00, 0,  0));
    vecs.push_back(mk(1, 7,  0, 0,  7,  3,  2'b01, 1,  3));
    vecs.push_back(mk(0, 0,  0, 0,  7,  3,  2'b11, 2,  3));
    vecs.push_back(mk(1, 0,  0, 0,  0,  0,  2'b00, 2,  3));
    vecs.push_back(mk(0, 0,  0, 0,  0,  7,  2'b01, 2,  3));
    vecs.push_back(mk(0, 0,  1, 0,  7,  3,  2'b11, 2,  3));
    vecs.push_back(mk(0, 0,  1, 0,  7,  3,  2'b10, 1,  7));
    vecs.push_back(mk(0, 0,  0, 0,  7,  3,  2'b00, 0,  0));
    vecs.push_back(mk(1, 6,  1, 0,  6,  6,  2'b00, 0,  0));
    vecs.push_back(mk(1, 6,  0, 0,  6,  6,  2'b11, 1,  6));
    vecs.push_back(mk(0, 0,  1, 0,  6,  6,  2'b11, 2,  6));
    vecs.push_back(mk(0, 0,  0, 0,  6,  6,  2'b11, 1,  6));
    vecs.push_back(mk(0, 0,  1, 0,  6,  6,  2'b11, 1,  6));
    vecs.push_back(mk(0, 0,  0, 0,  6,  6,  2'b00, 0,  0));
    vecs.push_back(mk(1, 1,  0, 0,  2,  1,  2'b00, 0,  0));
    vecs.push_back(mk(1, 2,  0, 0,  2,  1,  2'b01, 1,  1));
    vecs.push_back(mk(1, 3,  0, 0,  2,  1,  2'b11, 2,  1));
    vecs.push_back(mk(1, 4,  0, 0,  5,  4,  2'b00, 3,  1));
    vecs.push_back(mk(1, 5,  0, 0,  5,  4,  2'b01, 4,  1));
    vecs.push_back(mk(0, 0,  0, 0,  5,  4,  2'b01, 4,  1));
    vecs.push_back(mk(1, 9,  1, 0,  9,  1,  2'b01, 4,  1));
    vecs.push_back(mk(1, 9,  0, 0,  9,  1,  2'b00, 3,  2));
    vecs.push_back(mk(0, 0,  0, 0,  9,  1,  2'b10, 4,  2));
    vecs.push_back(mk(0, 0,  1, 0,  9,  2,  2'b11, 4,  2));
    vecs.push_back(mk(1, 2,  0, 1,  9,  2,  2'b10, 3,  3));
    vecs.push_back(mk(0, 0,  0, 0,  9,  2,  2'b00, 0,  0));
    vecs.push_back(mk(1, 5,  0, 0,  5,  0,  2'b00, 0,  0));
    vecs.push_back(mk(0, 0,  0, 0,  5,  0,  2'b10, 1,  5));
    vecs.push_back(mk(1, 8,  1, 0,  8,  5,  2'b01, 1,  5));
    vecs.push_back(mk(0, 0,  0, 0,  8,  5,  2'b10, 1,  8));

    // Reset held: outputs must already be in their reset state.
    #2;
    chk_all("reset", 2'b00, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].iv, vecs[i].idest, vecs[i].rv, vecs[i].fl, vecs[i].s1, vecs[i].s0);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].hz, vecs[i].cnt, vecs[i].rdest);
    end

    // Asynchronous reset in the middle of a busy stream: state is [8].
    @(negedge clock); drive(1, 11, 0, 0, 12, 11);
    @(negedge clock); drive(1, 12, 0, 0, 12, 11);
    @(negedge clock); drive(0, 0, 0, 0, 12, 11);
    #1;
    chk_all("pre_async_reset", 2'b11, 3, 8);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset_held", 2'b00, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_all("after_release", 2'b00, 0, 0);
    @(posedge clock);
    #1;
    chk_all("after_release_edge", 2'b00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
